// File: rtl/systolic_pkg.sv
`default_nettype none
// ============================================================================
// Module      : systolic_pkg
// Description : Shared constants, state encoding and tile-length helper for
//               the 4x4 systolic matrix-multiply sequencer and its neighbours.
// Revision    : 1.0 - initial release
// ============================================================================
package systolic_pkg;

    localparam int DIM          = 4;
    localparam int SKEW         = 2 * (DIM - 1);
    localparam int MAX_INST     = 8;
    localparam int TILE_ENTRIES = 16;

    typedef logic [2:0] state_t;

    localparam state_t c_ST_IDLE   = 3'd0;
    localparam state_t c_ST_FETCH  = 3'd1;
    localparam state_t c_ST_DECODE = 3'd2;
    localparam state_t c_ST_CLEAR  = 3'd3;
    localparam state_t c_ST_STREAM = 3'd4;
    localparam state_t c_ST_FLUSH  = 3'd5;
    localparam state_t c_ST_DRAIN  = 3'd6;
    localparam state_t c_ST_DONE   = 3'd7;

    // Number of operand columns streamed for one tile: inner dimension plus
    // skew padding, plus the separator column that precedes every tile but
    // the first in the operand layout.
    function automatic logic [4:0] tile_cols(input logic [3:0] l,
                                             input logic [4:0] skew,
                                             input logic       not_first);
        return 5'(l) + skew + 5'(not_first);
    endfunction

endpackage
`default_nettype wire

// File: rtl/systolic_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module      : systolic_ctrl_if
// Description : Host handshake plus instruction / operand / result memory
//               and array control bundle of the systolic sequencer.
//               master : sequencer side (drives addresses and enables)
//               slave  : host / memories / array side
// Revision    : 1.0 - initial release
// ============================================================================
interface systolic_ctrl_if #(
    parameter int COL_W = 8,
    parameter int OUT_W = 7
);
    logic             ap_start;
    logic             ap_done;
    logic             busy;
    logic [2:0]       addrI;
    logic [3:0]       dataI;
    logic [COL_W-1:0] mem_col;
    logic             mem_rd;
    logic             pe_clear;
    logic             pe_en;
    logic [3:0]       drain_idx;
    logic [OUT_W-1:0] addrO;
    logic             out_we;
    logic [3:0]       currInstruction;

    modport master (
        input  ap_start, dataI,
        output ap_done, busy, addrI, mem_col, mem_rd, pe_clear, pe_en,
               drain_idx, addrO, out_we, currInstruction
    );

    modport slave (
        output ap_start, dataI,
        input  ap_done, busy, addrI, mem_col, mem_rd, pe_clear, pe_en,
               drain_idx, addrO, out_we, currInstruction
    );
endinterface
`default_nettype wire

// File: rtl/systolic_stream_gen.sv
`default_nettype none
// ============================================================================
// Module      : systolic_stream_gen
// Description : Shared column/entry counter for the STREAM and DRAIN phases,
//               and the one-cycle read-enable to array-enable delay that
//               lines pe_en up with operand data returning from memory.
//   clk, rst  : clock, asynchronous active-high reset
//   i_step    : count this cycle (counter returns to 0 whenever low)
//   i_rd      : operand read issued this cycle
//   o_cnt     : current count, 0 on the first stepping cycle
//   o_pe_en   : i_rd delayed by one cycle
// Revision    : 1.0 - initial release
// ============================================================================
module systolic_stream_gen #(
    parameter int CNT_W = 5
) (
    input  wire logic             clk,
    input  wire logic             rst,
    input  wire logic             i_step,
    input  wire logic             i_rd,
    output logic      [CNT_W-1:0] o_cnt,
    output logic                  o_pe_en
);
    import systolic_pkg::*;

    logic [CNT_W-1:0] r_cnt;
    logic             r_pe_en;

    // Self-clearing: any non-counting cycle (CLEAR, FLUSH, FETCH...) rewinds
    // the counter so the next phase always starts at 0.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt   <= '0;
            r_pe_en <= 1'b0;
        end else begin
            r_cnt   <= i_step ? r_cnt + CNT_W'(1) : '0;
            r_pe_en <= i_rd;
        end
    end

    assign o_cnt   = r_cnt;
    assign o_pe_en = r_pe_en;

endmodule
`default_nettype wire

// File: rtl/systolic_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : systolic_ctrl
// Description : Sequencer for the 4x4 systolic matrix-multiply datapath.
//               Walks the instruction memory; for every nonzero entry it
//               clears the array, streams the skewed operand columns, and
//               drains the 16 accumulators into the result memory.
//   clk       : rising-edge clock
//   rst       : asynchronous active-high reset
//   bus       : systolic_ctrl_if.master - host handshake (ap_start/ap_done/
//               busy), instruction read (addrI/dataI), operand read
//               (mem_col/mem_rd), array control (pe_clear/pe_en/drain_idx),
//               result write (addrO/out_we) and currInstruction
// Revision    : 1.0 - initial release
// ============================================================================
module systolic_ctrl #(
    parameter int DIM      = systolic_pkg::DIM,
    parameter int MAX_INST = systolic_pkg::MAX_INST,
    parameter int COL_W    = 8,
    parameter int OUT_W    = 7
) (
    input  wire logic       clk,
    input  wire logic       rst,
    systolic_ctrl_if.master bus
);
    import systolic_pkg::*;

    localparam logic [4:0] c_SKEW       = 5'(2 * (DIM - 1));
    localparam logic [3:0] c_K_END      = 4'(MAX_INST);
    localparam logic [4:0] c_DRAIN_LAST = 5'(TILE_ENTRIES - 1);

    state_t           r_state;
    logic [3:0]       r_k;
    logic [3:0]       r_l;
    logic [4:0]       r_s;
    logic [COL_W-1:0] r_base;

    logic [4:0]       w_cnt;
    logic             w_pe_en;
    logic             w_stream;
    logic             w_drain;
    logic [3:0]       w_k_next;

    assign w_stream = (r_state == c_ST_STREAM);
    assign w_drain  = (r_state == c_ST_DRAIN);
    assign w_k_next = r_k + 4'd1;

    systolic_stream_gen #(
        .CNT_W (5)
    ) u_stream_gen (
        .clk     (clk),
        .rst     (rst),
        .i_step  (w_stream | w_drain),
        .i_rd    (w_stream),
        .o_cnt   (w_cnt),
        .o_pe_en (w_pe_en)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= c_ST_IDLE;
            r_k     <= '0;
            r_l     <= '0;
            r_s     <= '0;
            r_base  <= '0;
        end else begin
            case (r_state)
                c_ST_IDLE: begin
                    if (bus.ap_start) begin
                        r_k     <= '0;
                        r_base  <= '0;
                        r_state <= c_ST_FETCH;
                    end
                end
                c_ST_FETCH: begin
                    r_state <= c_ST_DECODE;
                end
                c_ST_DECODE: begin
                    r_l <= bus.dataI;
                    if (bus.dataI == 4'd0) begin
                        r_state <= c_ST_DONE;
                    end else begin
                        r_s     <= tile_cols(bus.dataI, c_SKEW, r_k != 4'd0);
                        r_state <= c_ST_CLEAR;
                    end
                end
                c_ST_CLEAR: begin
                    r_state <= c_ST_STREAM;
                end
                c_ST_STREAM: begin
                    if (w_cnt == r_s - 5'd1) begin
                        r_state <= c_ST_FLUSH;
                    end
                end
                c_ST_FLUSH: begin
                    // Next tile's columns start right after this tile's.
                    r_base  <= r_base + COL_W'(r_s);
                    r_state <= c_ST_DRAIN;
                end
                c_ST_DRAIN: begin
                    if (w_cnt == c_DRAIN_LAST) begin
                        r_k <= w_k_next;
                        // Full program: skip the fetch of a ninth entry.
                        r_state <= (w_k_next == c_K_END) ? c_ST_DONE : c_ST_FETCH;
                    end
                end
                c_ST_DONE: begin
                    r_state <= c_ST_IDLE;
                end
                default: begin
                    r_state <= c_ST_IDLE;
                end
            endcase
            // currInstruction reads 0 from the DONE cycle onwards.
            if ((r_state == c_ST_DRAIN) && (w_cnt == c_DRAIN_LAST) &&
                (w_k_next == c_K_END)) begin
                r_l <= '0;
            end
        end
    end

    // Outputs are decoded from registered state only; address buses are
    // forced to 0 outside their active phase.
    assign bus.ap_done         = (r_state == c_ST_DONE);
    assign bus.busy            = (r_state != c_ST_IDLE);
    assign bus.addrI           = (r_state == c_ST_FETCH) ? r_k[2:0] : 3'd0;
    assign bus.mem_rd          = w_stream;
    assign bus.mem_col         = w_stream ? (r_base + COL_W'(w_cnt)) : '0;
    assign bus.pe_clear        = (r_state == c_ST_CLEAR);
    assign bus.pe_en           = w_pe_en;
    assign bus.drain_idx       = w_drain ? w_cnt[3:0] : 4'd0;
    assign bus.addrO           = w_drain ? (OUT_W'({r_k, 4'b0000}) + OUT_W'(w_cnt[3:0])) : '0;
    assign bus.out_we          = w_drain;
    assign bus.currInstruction = r_l;

endmodule
`default_nettype wire

// File: tb/tb_systolic_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_systolic_ctrl
// Description : Self-checking bench for systolic_ctrl. A cycle-accurate
//               expectation of every output is queued per program and
//               compared cycle by cycle, followed by per-run totals.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_systolic_ctrl;
    import systolic_pkg::*;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    systolic_ctrl_if #(.COL_W(8), .OUT_W(7)) bus ();

    systolic_ctrl #(
        .DIM      (4),
        .MAX_INST (8),
        .COL_W    (8),
        .OUT_W    (7)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // Instruction memory: one-cycle read latency.
    logic [3:0] imem [8];
    always @(posedge clk) bus.dataI <= imem[bus.addrI];

    int n_pass  = 0;
    int n_fail  = 0;
    int n_total = 0;

    // Bit layout: [31]ap_done [30]busy [29]mem_rd [28]pe_clear [27]pe_en
    // [26]out_we [25:18]mem_col [17:14]drain_idx [13:7]addrO
    // [6:3]currInstruction [2:0]addrI
    typedef struct packed {
        logic [31:0] val;
        logic [31:0] mask;
    } exp_t;

    exp_t q[$];

    function automatic logic [31:0] obs();
        return {bus.ap_done, bus.busy, bus.mem_rd, bus.pe_clear, bus.pe_en,
                bus.out_we, bus.mem_col, bus.drain_idx, bus.addrO,
                bus.currInstruction, bus.addrI};
    endfunction

    task automatic check(input string tag, input int cyc,
                         input logic [31:0] o, input logic [31:0] e,
                         input logic [31:0] m);
        n_total++;
        assert ((o & m) === (e & m)) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s cyc=%0d observed=%h expected=%h mask=%h", tag, cyc, o & m, e & m, m);
        end
    endtask

    // care = {mem_col, drain_idx+addrO, currInstruction, addrI}
    task automatic push(input logic [5:0] ctl, input logic [7:0] col,
                        input logic [3:0] di, input logic [6:0] ao,
                        input logic [3:0] cur, input logic [2:0] ai,
                        input logic [3:0] care);
        exp_t e;
        e.val  = {ctl, col, di, ao, cur, ai};
        e.mask = {6'h3F, {8{care[3]}}, {11{care[2]}}, {4{care[1]}}, {3{care[0]}}};
        q.push_back(e);
    endtask

    // Expected per-cycle outputs, starting with the cycle after ap_start is
    // sampled, through DONE and n_idle following IDLE cycles.
    task automatic build(input int n_idle);
        int k, base, l, s;
        bit fin;
        k = 0; base = 0; fin = 1'b0;
        q.delete();
        while (!fin) begin
            push(6'b010000, 8'd0, 4'd0, 7'd0, 4'd0, 3'(k), 4'b0001);   // FETCH
            push(6'b010000, 8'd0, 4'd0, 7'd0, 4'd0, 3'd0, 4'b0000);    // DECODE
            l = int'(imem[k]);
            if (l == 0) begin
                fin = 1'b1;
            end else begin
                s = l + 6 + ((k != 0) ? 1 : 0);
                push(6'b010100, 8'd0, 4'd0, 7'd0, 4'(l), 3'd0, 4'b0010); // CLEAR
                for (int c = 0; c < s; c++)
                    push({3'b011, 1'b0, (c > 0), 1'b0}, 8'(base + c), 4'd0, 7'd0,
                         4'(l), 3'd0, 4'b1010);                          // STREAM
                push(6'b010010, 8'd0, 4'd0, 7'd0, 4'(l), 3'd0, 4'b0010); // FLUSH
                base += s;
                for (int c = 0; c < 16; c++)
                    push(6'b010001, 8'd0, 4'(c), 7'(16 * k + c), 4'(l), 3'd0,
                         4'b0110);                                       // DRAIN
                k++;
                if (k == 8) fin = 1'b1;
            end
        end
        push(6'b110000, 8'd0, 4'd0, 7'd0, 4'd0, 3'd0, 4'b0010);          // DONE
        repeat (n_idle) push(6'b000000, 8'd0, 4'd0, 7'd0, 4'd0, 3'd0, 4'b0010);
    endtask

    task automatic run(input string tag, input int poke1, input int poke2,
                       input int abort_at, output int writes,
                       output int last_col, output int dones, output int pes);
        exp_t e;
        int   i;
        writes = 0; last_col = -1; dones = 0; pes = 0;
        @(negedge clk);
        bus.ap_start = 1'b1;
        @(posedge clk);
        #1;
        bus.ap_start = 1'b0;
        i = 0;
        while (q.size() > 0) begin
            e = q.pop_front();
            if (i == abort_at) begin
                rst = 1'b1;
                #2;
                check({tag, "_rst_async"}, i, obs(), 32'h0, 32'hFFFF_FFFF);
                q.delete();
                break;
            end
            check(tag, i, obs(), e.val, e.mask);
            if (bus.out_we) writes++;
            if (bus.mem_rd) last_col = int'(bus.mem_col);
            if (bus.ap_done) dones++;
            if (bus.pe_en) pes++;
            bus.ap_start = (i == poke1) || (i == poke2);
            @(posedge clk);
            #1;
            i++;
        end
        bus.ap_start = 1'b0;
    endtask

    int wr, lc, dn, pe, done_idx;

    initial begin
        rst          = 1'b1;
        bus.ap_start = 1'b0;
        foreach (imem[j]) imem[j] = 4'd0;
        repeat (3) @(posedge clk);
        #1;
        check("reset", 0, obs(), 32'h0, 32'hFFFF_FFFF);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        check("idle_after_reset", 0, obs(), 32'h0, 32'hFFFF_FFFF);

        // Single tile L=4: 10 columns, 16 writes.
        imem[0] = 4'd4;
        build(2);
        run("p4", -1, -1, -1, wr, lc, dn, pe);
        check("p4_writes", 0, 32'(wr), 32'd16, 32'hFFFF_FFFF);
        check("p4_lastcol", 0, 32'(lc), 32'd9, 32'hFFFF_FFFF);
        check("p4_pe_en", 0, 32'(pe), 32'd10, 32'hFFFF_FFFF);
        check("p4_done", 0, 32'(dn), 32'd1, 32'hFFFF_FFFF);

        // Empty program.
        imem[0] = 4'd0;
        build(2);
        run("p0", -1, -1, -1, wr, lc, dn, pe);
        check("p0_writes", 0, 32'(wr), 32'd0, 32'hFFFF_FFFF);
        check("p0_reads", 0, 32'(lc), 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        check("p0_done", 0, 32'(dn), 32'd1, 32'hFFFF_FFFF);

        // Two tiles with separator column.
        imem[0] = 4'd2; imem[1] = 4'd3; imem[2] = 4'd0;
        build(2);
        run("p23", -1, -1, -1, wr, lc, dn, pe);
        check("p23_writes", 0, 32'(wr), 32'd32, 32'hFFFF_FFFF);
        check("p23_lastcol", 0, 32'(lc), 32'd17, 32'hFFFF_FFFF);

        // Full program of eight 15s: no ninth fetch.
        foreach (imem[j]) imem[j] = 4'd15;
        build(2);
        run("p15x8", -1, -1, -1, wr, lc, dn, pe);
        check("p15x8_writes", 0, 32'(wr), 32'd128, 32'hFFFF_FFFF);
        check("p15x8_lastcol", 0, 32'(lc), 32'd174, 32'hFFFF_FFFF);
        check("p15x8_done", 0, 32'(dn), 32'd1, 32'hFFFF_FFFF);

        // ap_start during STREAM and during DONE must be ignored.
        foreach (imem[j]) imem[j] = 4'd0;
        imem[0] = 4'd4;
        build(4);
        done_idx = q.size() - 5;
        run("poke", 5, done_idx, -1, wr, lc, dn, pe);
        check("poke_done", 0, 32'(dn), 32'd1, 32'hFFFF_FFFF);
        check("poke_writes", 0, 32'(wr), 32'd16, 32'hFFFF_FFFF);

        // Asynchronous reset mid-DRAIN (cycle 19 = 6th drain cycle).
        build(2);
        run("abort", -1, -1, 19, wr, lc, dn, pe);
        repeat (2) @(posedge clk);
        #1;
        check("rst_hold", 0, obs(), 32'h0, 32'hFFFF_FFFF);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        check("idle_after_abort", 0, obs(), 32'h0, 32'hFFFF_FFFF);

        imem[0] = 4'd2; imem[1] = 4'd3; imem[2] = 4'd0;
        build(2);
        run("rerun", -1, -1, -1, wr, lc, dn, pe);
        check("rerun_writes", 0, 32'(wr), 32'd32, 32'hFFFF_FFFF);
        check("rerun_lastcol", 0, 32'(lc), 32'd17, 32'hFFFF_FFFF);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire
